// File: rtl/svi_merge_pkg.sv
// rtl/svi_merge_pkg.sv - shared channel types and round-robin pick helper for svi_rr_merge
package svi_merge_pkg;

  localparam int MAX_CH = 16;
  localparam int IDX_W  = $clog2(MAX_CH);
  localparam int PW     = IDX_W + 1;

  typedef logic [IDX_W-1:0] chan_id_t;

  typedef struct packed {
    logic     found;
    chan_id_t idx;
  } pick_t;

  // First requester at or after ptr, wrapping from n-1 back to 0; callers keep ptr < n.
  function automatic pick_t rr_pick(input logic [MAX_CH-1:0] req, input chan_id_t ptr,
                                    input int n);
    pick_t         res;
    logic [PW-1:0] pos;
    res = '0;
    for (int k = MAX_CH - 1; k >= 0; k--) begin
      pos = {1'b0, ptr} + PW'(k);
      if (pos >= PW'(n)) pos = pos - PW'(n);
      if (k < n && req[pos[IDX_W-1:0]]) begin
        res.found = 1'b1;
        res.idx   = pos[IDX_W-1:0];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/I_vr.sv
// rtl/I_vr.sv - valid/ready channel carrying x, y, z payload members
interface I_vr #(parameter int WIDTH = 8);

  logic             valid;
  logic             ready;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic [WIDTH-1:0] z;

  modport Src (output valid, x, y, z, input ready);
  modport Snk (input valid, x, y, z, output ready);

endinterface

// File: rtl/svi_rr_arb.sv
// rtl/svi_rr_arb.sv - round-robin grant selection with optional grant lock while blocked
module svi_rr_arb
  import svi_merge_pkg::*;
#(
  parameter int  NUM_CH     = 4,
  parameter int  LOCK_GRANT = 1,
  localparam int IW         = $clog2(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] req_i,
  input  logic [IW-1:0]     ptr_i,
  input  logic              blocked_i,
  input  logic              xfer_i,
  output logic              gnt_vld_o,
  output logic [NUM_CH-1:0] gnt_oh_o,
  output logic [IW-1:0]     gnt_idx_o
);

  logic [MAX_CH-1:0] req_ext;
  chan_id_t          ptr_ext;
  pick_t             pick;
  logic              locked_q, locked_d;
  logic [IW-1:0]     lock_idx_q, lock_idx_d;
  logic              lock_live;
  logic              unused_pick;

  always_comb begin
    req_ext               = '0;
    req_ext[NUM_CH-1:0]   = req_i;
    ptr_ext               = '0;
    ptr_ext[IW-1:0]       = ptr_i;
    pick                  = rr_pick(req_ext, ptr_ext, NUM_CH);
  end

  assign unused_pick = ^pick.idx;
  assign lock_live   = (LOCK_GRANT != 0) && locked_q && req_i[lock_idx_q];

  always_comb begin
    gnt_vld_o = pick.found;
    gnt_idx_o = pick.idx[IW-1:0];
    if (lock_live) begin
      gnt_vld_o = 1'b1;
      gnt_idx_o = lock_idx_q;
    end
    gnt_oh_o = '0;
    if (gnt_vld_o) gnt_oh_o[gnt_idx_o] = 1'b1;
  end

  // A locked source that drops valid early loses its lock rather than stalling the merge.
  always_comb begin
    locked_d   = locked_q;
    lock_idx_d = lock_idx_q;
    if (xfer_i || (locked_q && !req_i[lock_idx_q])) begin
      locked_d = 1'b0;
    end else if ((LOCK_GRANT != 0) && blocked_i && pick.found && !locked_q) begin
      locked_d   = 1'b1;
      lock_idx_d = pick.idx[IW-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      locked_q   <= 1'b0;
      lock_idx_q <= '0;
    end else begin
      locked_q   <= locked_d;
      lock_idx_q <= lock_idx_d;
    end
  end

  a_lock_hold: assert property (@(posedge clk) disable iff (!rst_n)
    locked_q |-> req_i[lock_idx_q]);

endmodule

// File: rtl/svi_rr_merge.sv
// rtl/svi_rr_merge.sv - N-to-1 round-robin merge of valid/ready channels into one registered sink
module svi_rr_merge
  import svi_merge_pkg::*;
#(
  parameter int  NUM_CH     = 4,
  parameter int  WIDTH      = 8,
  parameter int  LOCK_GRANT = 1,
  localparam int IW         = $clog2(NUM_CH)
) (
  input  logic          clk,
  input  logic          rst_n,
  I_vr.Snk              s [NUM_CH],
  I_vr.Src              m,
  output logic [IW-1:0] grant_id
);

  logic [NUM_CH-1:0] req;
  logic [NUM_CH-1:0] rdy;
  logic [WIDTH-1:0]  x_in [NUM_CH];
  logic [WIDTH-1:0]  y_in [NUM_CH];
  logic [WIDTH-1:0]  z_in [NUM_CH];
  logic              full_q, full_d;
  logic [WIDTH-1:0]  x_q, x_d, y_q, y_d, z_q, z_d;
  logic [IW-1:0]     gid_q, gid_d, ptr_q, ptr_d;
  logic              gnt_vld;
  logic [NUM_CH-1:0] gnt_oh;
  logic [IW-1:0]     gnt_idx;
  logic              blocked;
  logic              load;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_src
    assign req[i]  = s[i].valid;
    assign x_in[i] = s[i].x;
    assign y_in[i] = s[i].y;
    assign z_in[i] = s[i].z;
    always_comb s[i].ready = rdy[i];
  end

  svi_rr_arb #(.NUM_CH(NUM_CH), .LOCK_GRANT(LOCK_GRANT)) u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_i     (req),
    .ptr_i     (ptr_q),
    .blocked_i (blocked),
    .xfer_i    (load),
    .gnt_vld_o (gnt_vld),
    .gnt_oh_o  (gnt_oh),
    .gnt_idx_o (gnt_idx)
  );

  // Ready is gated by reset so nothing handshakes while the output stage is held clear.
  assign blocked = full_q && !m.ready;
  assign load    = rst_n && !blocked && gnt_vld;
  assign rdy     = load ? gnt_oh : '0;

  always_comb begin
    full_d = full_q;
    x_d    = x_q;
    y_d    = y_q;
    z_d    = z_q;
    gid_d  = gid_q;
    ptr_d  = ptr_q;
    if (load) begin
      full_d = 1'b1;
      x_d    = x_in[gnt_idx];
      y_d    = y_in[gnt_idx];
      z_d    = z_in[gnt_idx];
      gid_d  = gnt_idx;
      ptr_d  = (gnt_idx == IW'(NUM_CH - 1)) ? '0 : gnt_idx + IW'(1);
    end else if (m.ready) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q <= 1'b0;
      x_q    <= '0;
      y_q    <= '0;
      z_q    <= '0;
      gid_q  <= '0;
      ptr_q  <= '0;
    end else begin
      full_q <= full_d;
      x_q    <= x_d;
      y_q    <= y_d;
      z_q    <= z_d;
      gid_q  <= gid_d;
      ptr_q  <= ptr_d;
    end
  end

  always_comb begin
    m.valid = full_q;
    m.x     = x_q;
    m.y     = y_q;
    m.z     = z_q;
  end

  assign grant_id = gid_q;

endmodule
